// File: rtl/comparator_3bit.sv
// Registered unsigned magnitude comparator: one cycle after A and B are sampled,
// exactly one of A_greater / A_equal / A_less is high (all low only under reset).
module comparator_3bit #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             A_greater,
    output logic             A_equal,
    output logic             A_less
);

    // Result packed as {greater, equal, less}; operands stay unsigned, no extension.
    function automatic logic [2:0] compare(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
        logic [2:0] r;
        r = 3'b000;
        if (a > b)
            r = 3'b100;
        else if (a == b)
            r = 3'b010;
        else
            r = 3'b001;
        return r;
    endfunction

    logic [2:0] flags_p0;

    always_comb begin
        flags_p0 = compare(A, B);
    end

    // Stage p0 -> p1: the only path to the outputs is through these flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            A_greater <= 1'b0;
            A_equal   <= 1'b0;
            A_less    <= 1'b0;
        end else begin
            A_greater <= flags_p0[2];
            A_equal   <= flags_p0[1];
            A_less    <= flags_p0[0];
        end
    end

endmodule

// File: tb/tb_comparator_3bit.sv
// Directed and random bench for comparator_3bit; flags are checked as {greater,equal,less}.
module tb_comparator_3bit;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] A;
    logic [2:0] B;
    logic       A_greater;
    logic       A_equal;
    logic       A_less;

    int total = 0;
    int bad   = 0;

    comparator_3bit #(.WIDTH(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .A_greater (A_greater),
        .A_equal   (A_equal),
        .A_less    (A_less)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] ref_cmp(input logic [2:0] a, input logic [2:0] b);
        if (a > b) return 3'b100;
        if (a == b) return 3'b010;
        return 3'b001;
    endfunction

    task automatic check(input string tag, input logic [2:0] exp);
        logic [2:0] got;
        got = {A_greater, A_equal, A_less};
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%b expected=%b (A=%0d B=%0d)", tag, got, exp, A, B);
        end
    endtask

    // Drive on the falling edge, check 1ns after the next rising edge.
    task automatic apply(input string tag, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] exp);
        @(negedge clk);
        A = a;
        B = b;
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    initial begin
        logic [2:0] ra;
        logic [2:0] rb;
        logic [2:0] ca;
        logic [2:0] cb;

        rst = 1'b1;
        A   = 3'd5;
        B   = 3'd2;
        #1;
        check("reset_init", 3'b000);
        @(posedge clk);
        #1;
        check("reset_hold", 3'b000);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("release_5_2", 3'b100);

        // Async reset between edges while showing 100
        #2;
        rst = 1'b1;
        #1;
        check("async_clear", 3'b000);
        @(posedge clk);
        #1;
        check("reset_hold_edge", 3'b000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("release_again", 3'b100);

        apply("eq_3_3", 3'd3, 3'd3, 3'b010);
        apply("eq_0_0", 3'd0, 3'd0, 3'b010);
        apply("eq_7_7", 3'd7, 3'd7, 3'b010);
        apply("gt_7_0", 3'd7, 3'd0, 3'b100);
        apply("gt_4_3", 3'd4, 3'd3, 3'b100);
        apply("lt_0_7", 3'd0, 3'd7, 3'b001);
        apply("lt_3_4", 3'd3, 3'd4, 3'b001);

        apply("b2b_2_5", 3'd2, 3'd5, 3'b001);
        apply("b2b_5_2", 3'd5, 3'd2, 3'b100);
        apply("b2b_6_6", 3'd6, 3'd6, 3'b010);

        // Operands change mid-cycle: outputs must hold until the next edge
        #2;
        A = 3'd1;
        B = 3'd6;
        #2;
        check("midcycle_hold", 3'b010);
        @(posedge clk);
        #1;
        check("midcycle_update", 3'b001);

        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                ca = 3'(a);
                cb = 3'(b);
                apply("sweep", ca, cb, ref_cmp(ca, cb));
            end
        end

        for (int i = 0; i < 10000; i++) begin
            ra = 3'($urandom_range(7, 0));
            rb = 3'($urandom_range(7, 0));
            apply("random", ra, rb, ref_cmp(ra, rb));
        end

        // Short reset pulse mid-stream, shorter than a clock period
        apply("pre_pulse_6_1", 3'd6, 3'd1, 3'b100);
        rst = 1'b1;
        #1;
        check("pulse_clear", 3'b000);
        #2;
        rst = 1'b0;
        #1;
        check("pulse_no_edge", 3'b000);
        A = 3'd2;
        B = 3'd2;
        @(posedge clk);
        #1;
        check("pulse_resume", 3'b010);
        apply("post_pulse_1_4", 3'd1, 3'd4, 3'b001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
